// File: rtl/tick_delay_ctrl_if.sv
// tick_delay_ctrl_if: control/status bundle between user logic, the tick divider and tick_delay_ctrl
interface tick_delay_ctrl_if #(parameter int WIDTH = 16);
  logic             start;
  logic             pause;
  logic             clear;
  logic [WIDTH-1:0] load_val;
  logic             tick;
  logic             div_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;
  logic [1:0]       state;
  modport master (
    output start, pause, clear, load_val, tick,
    input  div_en, busy, done, remaining, state
  );
  modport slave (
    input  start, pause, clear, load_val, tick,
    output div_en, busy, done, remaining, state
  );
endinterface

// File: rtl/tick_delay_ctrl.sv
// tick_delay_ctrl: counts divider ticks down from a loaded value; TICK_DELAY_RELOAD_EN enables periodic reload
module tick_delay_ctrl #(
  parameter int WIDTH = 16
) (
  input logic               clkin,
  input logic               rst_n,
  tick_delay_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             last_tick;
`ifdef TICK_DELAY_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif
  assign last_tick = bus.tick && rem_q <= WIDTH'(1);
  // state, counter and done pulse registers
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end
`ifdef TICK_DELAY_RELOAD_EN
  // period captured on every fresh start
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) reload_q <= '0;
    else        reload_q <= reload_d;
  end
`endif
  // next-state: clear dominates, final tick beats pause, ticks only count in RUN
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
`ifdef TICK_DELAY_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.clear) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) begin
          state_d = bus.load_val != '0 ? RUN : DONE;
          rem_d   = bus.load_val;
          done_d  = bus.load_val == '0;
`ifdef TICK_DELAY_RELOAD_EN
          reload_d = bus.load_val;
`endif
        end
        RUN: begin
          if (last_tick) begin
            done_d  = 1'b1;
`ifdef TICK_DELAY_RELOAD_EN
            state_d = reload_q != '0 ? RUN : DONE;
            rem_d   = reload_q;
`else
            state_d = DONE;
            rem_d   = '0;
`endif
          end else begin
            rem_d   = bus.tick ? rem_q - WIDTH'(1) : rem_q;
            state_d = bus.pause ? PAUSE : RUN;
          end
        end
        default: state_d = bus.start ? RUN : PAUSE;
      endcase
    end
  end
  // status decodes straight from the registers
  always_comb begin
    bus.div_en    = state_q == RUN;
    bus.busy      = state_q == RUN || state_q == PAUSE;
    bus.done      = done_q;
    bus.remaining = rem_q;
    bus.state     = state_q;
  end
endmodule

// File: tb/tb_tick_delay_ctrl.sv
// tb_tick_delay_ctrl: directed checks of tick_delay_ctrl (periodic checks when TICK_DELAY_RELOAD_EN is set)
module tb_tick_delay_ctrl;
  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  tick_delay_ctrl_if #(.WIDTH(16)) bus ();
  tick_delay_ctrl #(.WIDTH(16)) dut (.clkin(clkin), .rst_n(rst_n), .bus(bus));
  always #5 clkin = ~clkin;
  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clkin);
    #1;
  endtask
  task automatic cyc(input int n);
    repeat (n) step();
  endtask
  task automatic tick_pulse();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask
  task automatic go(input logic [15:0] v);
    bus.load_val = v;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b0;
    bus.tick = 1'b0;
    bus.load_val = '0;
    cyc(2);
    chk("rst_state", bus.state, 0);
    chk("rst_rem", bus.remaining, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_div_en", bus.div_en, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    step();
`ifndef TICK_DELAY_RELOAD_EN
    go(16'd3);
    chk("os_div_en", bus.div_en, 1);
    chk("os_busy", bus.busy, 1);
    chk("os_rem_load", bus.remaining, 3);
    for (int i = 1; i <= 3; i++) begin
      cyc(499);
      chk("os_done_pre", bus.done, 0);
      tick_pulse();
      chk("os_rem", bus.remaining, 3 - i);
    end
    chk("os_done", bus.done, 1);
    chk("os_state", bus.state, 3);
    chk("os_busy_done", bus.busy, 0);
    chk("os_div_en_done", bus.div_en, 0);
    step();
    chk("os_done_one", bus.done, 0);
    chk("os_state_hold", bus.state, 3);
    go(16'd5);
    tick_pulse();
    cyc(3);
    tick_pulse();
    chk("pr_rem2", bus.remaining, 3);
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    chk("pr_state", bus.state, 2);
    chk("pr_div_en", bus.div_en, 0);
    chk("pr_busy", bus.busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick_pulse();
      cyc(2);
    end
    chk("pr_rem_hold", bus.remaining, 3);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("pr_resume", bus.state, 1);
    tick_pulse();
    tick_pulse();
    chk("pr_rem1", bus.remaining, 1);
    chk("pr_done_pre", bus.done, 0);
    tick_pulse();
    chk("pr_done", bus.done, 1);
    chk("pr_end_state", bus.state, 3);
    go(16'd2);
    tick_pulse();
    chk("cl_rem1", bus.remaining, 1);
    bus.tick = 1'b1;
    bus.clear = 1'b1;
    step();
    bus.tick = 1'b0;
    bus.clear = 1'b0;
    chk("cl_state", bus.state, 0);
    chk("cl_rem", bus.remaining, 0);
    chk("cl_done", bus.done, 0);
    step();
    chk("cl_done_after", bus.done, 0);
    go(16'd0);
    chk("z_state", bus.state, 3);
    chk("z_done", bus.done, 1);
    chk("z_div_en", bus.div_en, 0);
    step();
    chk("z_done_one", bus.done, 0);
    go(16'd4);
    bus.tick = 1'b1;
    bus.pause = 1'b1;
    step();
    bus.tick = 1'b0;
    bus.pause = 1'b0;
    chk("tp_rem", bus.remaining, 3);
    chk("tp_state", bus.state, 2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    tick_pulse();
    tick_pulse();
    bus.tick = 1'b1;
    bus.pause = 1'b1;
    step();
    bus.tick = 1'b0;
    bus.pause = 1'b0;
    chk("fp_state", bus.state, 3);
    chk("fp_done", bus.done, 1);
    go(16'd6);
    go(16'd9);
    chk("ign_start_rem", bus.remaining, 6);
    chk("ign_start_state", bus.state, 1);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
`else
    go(16'd2);
    for (int i = 1; i <= 6; i++) begin
      cyc(2);
      chk("rl_done_gap", bus.done, 0);
      chk("rl_div_en_gap", bus.div_en, 1);
      tick_pulse();
      chk("rl_done", bus.done, (i % 2 == 0) ? 1 : 0);
      chk("rl_state", bus.state, 1);
      chk("rl_rem", bus.remaining, (i % 2 == 0) ? 2 : 1);
    end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("rl_clear", bus.state, 0);
    go(16'd0);
    chk("rl_zero_state", bus.state, 3);
    chk("rl_zero_done", bus.done, 1);
    step();
`endif
    go(16'd7);
    chk("ar_rem_pre", bus.remaining, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", bus.state, 0);
    chk("ar_rem", bus.remaining, 0);
    chk("ar_div_en", bus.div_en, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_done", bus.done, 0);
    rst_n = 1'b1;
    step();
    chk("ar_done_after", bus.done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
